// File: rtl/mem_port_arbiter_pkg.sv
// arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_e : FSM encoding for IDLE / ACCESS / RESP
//   OWN_CPU / OWN_DMA : requester identifiers used for owner and grant_id
//   CNT_W : width of the access-latency counter (enough for MEM_LAT up to 15)
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the CPU request channel, the DMA request channel
// and the memory-side signals of the arbiter.
//   slave  : the arbiter's view (takes requests and mem_in; drives strobes,
//            address/data, read data, acks, busy and owner)
//   master : the surrounding system's view (CPU, DMA and the memory block)
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;

  logic          read;
  logic          write;
  logic [AW-1:0] address;
  logic [DW-1:0] mem_out;
  logic [DW-1:0] mem_in;

  logic          busy;
  logic          owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_in,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    output read, write, address, mem_out, busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_in,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    input  read, write, address, mem_out, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// arb_rr_pick: combinational tie-breaker for the two requesters.
//   cpu_req, dma_req : current request levels
//   last_owner       : most recent grantee (OWN_CPU / OWN_DMA)
//   grant_valid      : at least one request is present
//   grant_id         : requester to grant (meaningful only with grant_valid)
// FIXED_PRIO=1 makes the CPU win every tie; otherwise a tie goes to whoever
// was not served last, which yields strict alternation under full load.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_id
);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    grant_valid = cpu_req | dma_req;
    grant_id    = OWN_CPU;
    if (cpu_req && dma_req) begin
      grant_id = (FIXED_PRIO != 0) ? OWN_CPU : ~last_owner;
    end else if (dma_req) begin
      grant_id = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the CPU and the DMA/loader.
//   clk   : system clock, all state changes on the rising edge
//   rst_b : synchronous reset, active-high
//   bus   : request channels, memory strobes/address/data, acks, busy, owner
// A grant in IDLE latches the grantee's address, write data and direction;
// ACCESS holds the strobe for exactly MEM_LAT cycles (MEM_LAT in 1..15), a read
// captures mem_in in the final strobe cycle, and RESP pulses the owner's ack.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int FIXED_PRIO = 0,
  parameter int AW         = 16,
  parameter int DW         = 16
) (
  input logic             clk,
  input logic             rst_b,
  mem_port_arbiter_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;      // 1 = write
  logic             owner_q;    // doubles as last_owner for the tie-breaker
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    cpu_rdata_q;
  logic [DW-1:0]    dma_rdata_q;
  logic             grant_valid;
  logic             grant_id;

  arb_rr_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .cpu_req     (bus.cpu_req),
    .dma_req     (bus.dma_req),
    .last_owner  (owner_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_b) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant latches, latency counter and read-data capture. The counter is
  // loaded with MEM_LAT-1 and only decremented while non-zero, so MEM_LAT=1
  // leaves ACCESS after a single cycle without wrapping.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      owner_q     <= OWN_DMA;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (state_q == IDLE && grant_valid) begin
        owner_q <= grant_id;
        cnt_q   <= CNT_W'(MEM_LAT - 1);
        if (grant_id == OWN_DMA) begin
          addr_q  <= bus.dma_addr;
          wdata_q <= bus.dma_wdata;
          dir_q   <= bus.dma_we;
        end else begin
          addr_q  <= bus.cpu_addr;
          wdata_q <= bus.cpu_wdata;
          dir_q   <= bus.cpu_we;
        end
      end else if (state_q == ACCESS) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end else if (!dir_q) begin
          if (owner_q == OWN_DMA) dma_rdata_q <= bus.mem_in;
          else                    cpu_rdata_q <= bus.mem_in;
        end
      end
    end
  end

  // Output logic: strobes only in ACCESS, ack only in RESP.
  always_comb begin
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.cpu_ack = 1'b0;
    bus.dma_ack = 1'b0;
    unique case (state_q)
      ACCESS: begin
        bus.read  = ~dir_q;
        bus.write = dir_q;
      end
      RESP: begin
        if (owner_q == OWN_DMA) bus.dma_ack = 1'b1;
        else                    bus.cpu_ack = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.address   = addr_q;
  assign bus.mem_out   = wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 16-bit memory port between two requesters: the CPU (read/write strobes, address, data) and a DMA/loader channel serving the Input/Output units.
- Grants one requester at a time and latches its address, write data and direction.
- Drives the memory strobes for a fixed access latency, returns read data, and pulses a per-requester acknowledge.
- Sits between the CPU/DMA masters and the memory block.

Parameters:
- MEM_LAT, 1, memory access length in cycles (1..15); strobes are held for exactly MEM_LAT cycles.
- FIXED_PRIO, 0, 0 = round-robin on ties; 1 = CPU always wins ties.
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_b  in  1  synchronous reset, active-high (asserted = 1, sampled on clk).
- cpu_req  in  1  CPU access request, level; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  read data returned to CPU.
- cpu_ack  out  1  one-cycle completion pulse to CPU.
- dma_req  in  1  DMA access request, level.
- dma_we  in  1  1 = write.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_rdata  out  DW  read data returned to DMA.
- dma_ack  out  1  one-cycle completion pulse to DMA.
- read  out  1  memory read strobe.
- write  out  1  memory write strobe.
- address  out  AW  memory address.
- mem_out  out  DW  memory write data.
- mem_in  in  DW  memory read data.
- busy  out  1  high in every state other than IDLE.
- owner  out  1  current or last grantee: 0 = CPU, 1 = DMA.

Behaviour:
- Reset (rst_b=1 at an edge, including mid-access):
  - state -> IDLE; counter -> 0.
  - read, write, cpu_ack, dma_ack, busy -> 0.
  - address, mem_out, cpu_rdata, dma_rdata -> 0.
  - last_owner -> 1 (DMA), so the CPU wins the first tie.
  - An aborted access issues no ack.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - No request: remain in IDLE.
  - Only one request: grant that requester.
  - Both requests:
    - FIXED_PRIO=1: grant CPU.
    - FIXED_PRIO=0: grant the requester that is not last_owner.
  - On grant, same edge:
    - Latch the grantee's addr/wdata/we into address/mem_out/dir.
    - Set owner and last_owner to the grantee; counter <- MEM_LAT-1.
    - Move to ACCESS.
- ACCESS:
  - read = ~dir, write = dir, for exactly MEM_LAT consecutive cycles.
  - address and mem_out stay stable for the whole access.
  - Counter decrements each cycle.
  - In the cycle with counter == 0:
    - For a read, capture mem_in into the owner's rdata register.
    - Go to RESP.
- RESP:
  - Strobes are 0.
  - Owner's ack = 1 for this single cycle.
  - Next state IDLE.
- Latency: request first seen in IDLE at edge t → strobes cycles t+1..t+MEM_LAT → ack in cycle t+MEM_LAT+1. Minimum turnaround is MEM_LAT+2 cycles per access.
- Handshake:
  - A requester must drop req in the cycle after its ack. A req still high in the following IDLE cycle is treated as a new request.
  - Deasserting req during ACCESS does not cancel the access; it completes and the ack is still issued.
  - Changes to addr/wdata after grant are ignored.
- rdata registers hold their value until overwritten by the next read for the same requester. Writes do not modify rdata.
- cpu_ack and dma_ack are never high in the same cycle. read and write are never high in the same cycle.
- Fairness: in round-robin mode, with both requesters continuously active, grants alternate strictly. Worst-case wait is one foreign access (MEM_LAT+2 cycles).
- MEM_LAT=1 must work: one strobe cycle, no counter underflow.

Decomposition:
- Shared package arb_pkg:
  - State encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Owner constants: OWN_CPU=1'b0, OWN_DMA=1'b1.
- One natural sub-module: arb_rr_pick, the combinational tie-breaker. Inputs: cpu_req, dma_req, last_owner, FIXED_PRIO. Outputs: grant_valid, grant_id.
- FSM, counter and latches live in the top module.

Test Plan:
- Reset then CPU read, MEM_LAT=1, cpu_addr=16'h0040, mem_in=16'hBEEF → read=1 for one cycle with address=0040; cpu_ack one cycle later; cpu_rdata=BEEF; dma_ack=0 throughout.
- DMA write, MEM_LAT=3, dma_addr=16'h0123, dma_wdata=16'h5A5A → write=1 for exactly 3 cycles with address=0123 and mem_out=5A5A; dma_ack in the 4th cycle after grant; dma_rdata unchanged.
- Both requesting from reset, round-robin, requesters re-raise req after each ack → grant order CPU, DMA, CPU, DMA. Set FIXED_PRIO=1 and rerun → all grants go to CPU while cpu_req stays high.
- CPU changes cpu_addr from 0010 to 0020 mid-access, and drops cpu_req during ACCESS → address stays 0010; cpu_ack still pulses once.
- rst_b=1 during ACCESS of a DMA read with MEM_LAT=4 → next cycle: read=0, busy=0, no dma_ack, dma_rdata=0. The next tie after reset goes to CPU.
- cpu_req held high across its ack with MEM_LAT=2 → a second access starts in the IDLE cycle after RESP. Check strobe gap = 2 cycles and exactly two acks.
